// File: rtl/coax_clock_gen.sv
// coax_clock_gen: PLL lock filter, system reset sequencer and bit-phase
// strobe generator. Optional macro: COAX_CLOCK_GEN_LOCK_LOSS_COUNT_EN.
module coax_clock_gen #(
    parameter int DIVIDER           = 8,
    parameter int PHASES            = 2,
    parameter int LOCK_FILTER       = 16,
    parameter int RESET_HOLD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              enable,
    input  logic              sync,
    output logic              sys_reset,
    output logic              ready,
    output logic              bit_strobe,
    output logic [PHASES-1:0] phase_strobe
`ifdef COAX_CLOCK_GEN_LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]        lock_loss_count
`endif
);

    localparam int CW   = $clog2(DIVIDER);
    localparam int FW   = $clog2(LOCK_FILTER + 1);
    localparam int HW   = $clog2(RESET_HOLD_CYCLES + 1);
    localparam int STEP = DIVIDER / PHASES;

    generate
        if (DIVIDER < 2) begin : g_bad_divider
            $error("coax_clock_gen: DIVIDER must be >= 2");
        end
        if (DIVIDER % PHASES != 0) begin : g_bad_phases
            $error("coax_clock_gen: DIVIDER must be a multiple of PHASES");
        end
        if (LOCK_FILTER < 1) begin : g_bad_filter
            $error("coax_clock_gen: LOCK_FILTER must be >= 1");
        end
        if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
            $error("coax_clock_gen: RESET_HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            lock_m;
    logic            lock_s;
    logic [FW-1:0]   filt;
    logic [HW-1:0]   hold;
    logic [CW-1:0]   cnt;

    // Two-flop synchroniser for the asynchronous PLL lock input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // State register; sys_reset and ready follow the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_LOCK;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state     <= state_n;
            sys_reset <= (state_n != RUN);
            ready     <= (state_n == RUN);
        end
    end

    // Next-state: filter the lock, hold reset, drop out on any lock loss
    always_comb begin
        state_n = state;
        case (state)
            WAIT_LOCK: begin
                if (lock_s && filt == FW'(LOCK_FILTER - 1))
                    state_n = HOLD;
            end
            HOLD: begin
                if (!lock_s)
                    state_n = WAIT_LOCK;
                else if (hold == HW'(RESET_HOLD_CYCLES - 1))
                    state_n = RUN;
            end
            RUN: begin
                if (!lock_s)
                    state_n = WAIT_LOCK;
            end
            default: state_n = WAIT_LOCK;
        endcase
    end

    // Lock filter and reset hold counters, cleared whenever the state changes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
            hold <= '0;
        end else begin
            if (state == WAIT_LOCK && lock_s && state_n == WAIT_LOCK)
                filt <= filt + FW'(1);
            else
                filt <= '0;
            if (state == HOLD && state_n == HOLD)
                hold <= hold + HW'(1);
            else
                hold <= '0;
        end
    end

    // Bit-period counter: runs in RUN with enable, realigned by sync
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_n != RUN) begin
            cnt <= '0;
        end else if (state == RUN && enable) begin
            if (sync || cnt == CW'(DIVIDER - 1))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    // Phase strobes decoded from the counter, suppressed on a sync cycle
    always_comb begin
        phase_strobe = '0;
        for (int k = 0; k < PHASES; k++) begin
            if (state == RUN && enable && !sync && cnt == CW'(k * STEP))
                phase_strobe[k] = 1'b1;
        end
    end

    assign bit_strobe = phase_strobe[0];

`ifdef COAX_CLOCK_GEN_LOCK_LOSS_COUNT_EN
    // Saturating count of lock losses seen in HOLD or RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_loss_count <= 8'd0;
        end else if (state != WAIT_LOCK && state_n == WAIT_LOCK &&
                     lock_loss_count != 8'hFF) begin
            lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coax_clock_gen.sv
// tb_coax_clock_gen: directed and randomized checks of coax_clock_gen
// against a lock-streak / bit-position reference model.
module tb_coax_clock_gen;

    localparam int DIV  = 8;
    localparam int PH   = 2;
    localparam int LF   = 4;
    localparam int RH   = 16;
    localparam int STEP = DIV / PH;

    logic          clk = 1'b0;
    logic          reset;
    logic          pll_lock;
    logic          enable;
    logic          sync;
    logic          sys_reset;
    logic          ready;
    logic          bit_strobe;
    logic [PH-1:0] phase_strobe;
`ifdef COAX_CLOCK_GEN_LOCK_LOSS_COUNT_EN
    logic [7:0]    lock_loss_count;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: lock pipeline, run of consecutive synced-high
    // samples, position within the bit period, loss count
    bit m_s1, m_s2;
    int streak;
    int pos;
    int loss;

    coax_clock_gen #(
        .DIVIDER(DIV),
        .PHASES(PH),
        .LOCK_FILTER(LF),
        .RESET_HOLD_CYCLES(RH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_lock(pll_lock),
        .enable(enable),
        .sync(sync),
        .sys_reset(sys_reset),
        .ready(ready),
        .bit_strobe(bit_strobe),
        .phase_strobe(phase_strobe)
`ifdef COAX_CLOCK_GEN_LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_count(lock_loss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_run();
        return streak >= LF + RH;
    endfunction

    task automatic model_reset();
        m_s1 = 0;
        m_s2 = 0;
        streak = 0;
        pos = 0;
        loss = 0;
    endtask

    task automatic model_edge(input bit l, input bit e, input bit s);
        bit was_run;
        bit now_run;
        was_run = m_run();
        if (m_s2) begin
            if (streak < 1000000) streak = streak + 1;
        end else begin
            if (streak >= LF && loss < 255) loss = loss + 1;
            streak = 0;
        end
        m_s2 = m_s1;
        m_s1 = l;
        now_run = m_run();
        if (!now_run) pos = 0;
        else if (was_run && e) pos = s ? 0 : (pos + 1) % DIV;
    endtask

    task automatic check(input string tag);
        logic [PH-1:0] exp_ps;
        logic          run;
        run = m_run();
        exp_ps = '0;
        if (run && enable && !sync && (pos % STEP) == 0)
            exp_ps[pos / STEP] = 1'b1;
        checks++;
        assert (ready === run) else begin
            errors++;
            $error("FAIL %s ready got %b want %b", tag, ready, run);
        end
        checks++;
        assert (sys_reset === !run) else begin
            errors++;
            $error("FAIL %s sys_reset got %b want %b", tag, sys_reset, !run);
        end
        checks++;
        assert (phase_strobe === exp_ps) else begin
            errors++;
            $error("FAIL %s phase_strobe got %b want %b",
                   tag, phase_strobe, exp_ps);
        end
        checks++;
        assert (bit_strobe === exp_ps[0]) else begin
            errors++;
            $error("FAIL %s bit_strobe got %b want %b",
                   tag, bit_strobe, exp_ps[0]);
        end
`ifdef COAX_CLOCK_GEN_LOCK_LOSS_COUNT_EN
        checks++;
        assert (lock_loss_count === 8'(loss)) else begin
            errors++;
            $error("FAIL %s lock_loss_count got %0d want %0d",
                   tag, lock_loss_count, loss);
        end
`endif
    endtask

    // drive one cycle of inputs, check, then advance model and clock
    task automatic tick(input bit l, input bit e, input bit s,
                        input string tag);
        pll_lock = l;
        enable = e;
        sync = s;
        #1 check(tag);
        @(posedge clk);
        model_edge(l, e, s);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input string tag);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) begin
            #1 check(tag);
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    task automatic run_to_pos(input int p, input string tag);
        for (int i = 0; i < 2 * DIV && pos != p; i++)
            tick(1, 1, 0, tag);
        checks++;
        assert (pos == p) else begin
            errors++;
            $error("FAIL %s position got %0d want %0d", tag, pos, p);
        end
    endtask

    initial begin
        int n;
        pll_lock = 0;
        enable = 1;
        sync = 0;
        model_reset();

        // power-up reset and no lock
        do_reset(5, "reset");
        for (int i = 0; i < 20; i++)
            tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 "nolock");

        // lock rises: ready must appear 2+4+16 cycles later
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick(1, 1, 0, "lockup");
            n++;
        end
        checks++;
        assert (n == 2 + LF + RH) else begin
            errors++;
            $error("FAIL lock_latency got %0d want %0d", n, 2 + LF + RH);
        end
        for (int i = 0; i < 24; i++) tick(1, 1, 0, "strobes");

        // lock loss in RUN, then a glitch restarting the filter
        for (int i = 0; i < 6; i++) tick(0, 1, 0, "drop");
        for (int i = 0; i < 3; i++) tick(1, 1, 0, "pre_glitch");
        tick(0, 1, 0, "glitch");
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick(1, 1, 0, "relock");
            n++;
        end
        checks++;
        assert (n == 2 + LF + RH) else begin
            errors++;
            $error("FAIL glitch_latency got %0d want %0d", n, 2 + LF + RH);
        end

        // sync mid-period and at the wrap point
        run_to_pos(5, "to5");
        tick(1, 1, 1, "sync5");
        for (int i = 0; i < 12; i++) tick(1, 1, 0, "after5");
        run_to_pos(7, "to7");
        tick(1, 1, 1, "sync7");
        for (int i = 0; i < 12; i++) tick(1, 1, 0, "after7");

        // pause at position 3
        run_to_pos(3, "to3");
        for (int i = 0; i < 10; i++) tick(1, 0, 1'($urandom_range(0, 1)),
                                          "paused");
        checks++;
        assert (pos == 3) else begin
            errors++;
            $error("FAIL pause_hold got %0d want 3", pos);
        end
        for (int i = 0; i < 10; i++) tick(1, 1, 0, "resume");

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            tick(1'($urandom_range(0, 99) != 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 15) == 0), "random");

        // asynchronous reset mid-operation
        for (int i = 0; i < 30; i++) tick(1, 1, 0, "prerst");
        do_reset(3, "async_rst");
        for (int i = 0; i < 30; i++) tick(1, 1, 0, "postrst");

        // many losses: counter saturates
        for (int j = 0; j < 260; j++) begin
            for (int i = 0; i < 8; i++) tick(1, 1, 0, "loss_hi");
            for (int i = 0; i < 4; i++) tick(0, 1, 0, "loss_lo");
        end
        checks++;
        assert (loss == 255) else begin
            errors++;
            $error("FAIL loss_model got %0d want 255", loss);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
